// File: rtl/vita_pixel_capture.sv
// Bit-serial multi-lane pixel capture: two pixels per lane assembled into a kernel.
// Define VITA_CAPTURE_MIRROR_EN to mirror the lane/pixel mapping on odd kernels.
module vita_pixel_capture #(
  parameter int LANES    = 4,
  parameter int PIX_BITS = 8
) (
  input  logic                           pclock,
  input  logic                           reset,
  input  logic [LANES-1:0]               data,
  input  logic                           record_in,
  input  logic                           flush,
  output logic [2*LANES*PIX_BITS-1:0]    pixels,
  output logic                           valid,
  output logic                           kernel_odd,
  output logic [15:0]                    kernel_count
);

  localparam int KW = 2 * LANES * PIX_BITS;
  localparam int PW = $clog2(2 * PIX_BITS);
  localparam logic [PW-1:0] LAST = PW'(2 * PIX_BITS - 1);

  typedef logic [LANES-1:0][PIX_BITS-1:0] slot_t;

  logic [PW-1:0] p_q, p_d;
  logic          par_q, par_d;
  slot_t         sa_q, sa_d;
  slot_t         sb_q, sb_d;
  slot_t         sa_sh, sb_sh;
  logic [KW-1:0] pix_q, pix_d;
  logic          valid_q, valid_d;
  logic          odd_q, odd_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [KW-1:0] kern_even;
  logic [KW-1:0] kern_sel;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sa_sh[i] = {sa_q[i][PIX_BITS-2:0], data[i]};
      sb_sh[i] = {sb_q[i][PIX_BITS-2:0], data[i]};
    end
  end

  // Slot B still lacks its final bit, so the kernel uses the shifted value
  always_comb begin
    kern_even = '0;
    for (int i = 0; i < LANES; i++) begin
      kern_even[KW-(2*i+1)*PIX_BITS +: PIX_BITS] = sa_q[i];
      kern_even[KW-(2*i+2)*PIX_BITS +: PIX_BITS] = sb_sh[i];
    end
  end

`ifdef VITA_CAPTURE_MIRROR_EN
  logic [KW-1:0] kern_mir;

  always_comb begin
    kern_mir = '0;
    for (int i = 0; i < LANES; i++) begin
      kern_mir[KW-(2*(LANES-1-i)+2)*PIX_BITS +: PIX_BITS] = sa_q[i];
      kern_mir[KW-(2*(LANES-1-i)+1)*PIX_BITS +: PIX_BITS] = sb_sh[i];
    end
  end

  assign kern_sel = par_q ? kern_mir : kern_even;
`else
  assign kern_sel = kern_even;
`endif

  always_comb begin
    p_d     = p_q;
    par_d   = par_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      p_d   = '0;
      par_d = 1'b0;
      sa_d  = '0;
      sb_d  = '0;
      cnt_d = '0;
    end else if (record_in) begin
      if (!p_q[0]) begin
        sa_d = sa_sh;
      end else begin
        sb_d = sb_sh;
      end
      if (p_q == LAST) begin
        p_d     = '0;
        par_d   = ~par_q;
        pix_d   = kern_sel;
        valid_d = 1'b1;
        odd_d   = par_q;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      p_q     <= '0;
      par_q   <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      odd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      p_q     <= p_d;
      par_q   <= par_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pixels       = pix_q;
  assign valid        = valid_q;
  assign kernel_odd   = odd_q;
  assign kernel_count = cnt_q;

endmodule

// File: tb/tb_vita_pixel_capture.sv
// Bench for vita_pixel_capture: vector table, scoreboard and corner sequences.
module tb_vita_pixel_capture;

  localparam int L  = 4;
  localparam int PB = 8;
  localparam int KW = 2 * L * PB;
`ifdef VITA_CAPTURE_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic          pclock = 1'b0;
  logic          reset;
  logic [L-1:0]  data;
  logic          record_in;
  logic          flush;
  logic [KW-1:0] pixels;
  logic          valid;
  logic          kernel_odd;
  logic [15:0]   kernel_count;

  logic [0:0]    data1;
  logic          rec1;
  logic          flush1;
  logic [19:0]   pixels1;
  logic          valid1;
  logic          odd1;
  logic [15:0]   cnt1;

  always #5 pclock = ~pclock;

  vita_pixel_capture #(.LANES(L), .PIX_BITS(PB)) u0 (
    .pclock(pclock), .reset(reset), .data(data),
    .record_in(record_in), .flush(flush), .pixels(pixels),
    .valid(valid), .kernel_odd(kernel_odd),
    .kernel_count(kernel_count)
  );

  vita_pixel_capture #(.LANES(1), .PIX_BITS(10)) u1 (
    .pclock(pclock), .reset(reset), .data(data1),
    .record_in(rec1), .flush(flush1), .pixels(pixels1),
    .valid(valid1), .kernel_odd(odd1),
    .kernel_count(cnt1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          gap_at;
    int          gap_len;
    logic [63:0] exp_even;
    logic [63:0] exp_mir;
  } vec_t;

  typedef struct {
    logic [63:0] pix;
    logic        odd;
    logic [15:0] cnt;
    int          cyc;
    string       name;
  } exp_t;

  vec_t        vt[7];
  exp_t        sbq[$];
  exp_t        me;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc_n = 0;
  logic        mpar;
  logic [15:0] mcnt;
  logic [63:0] last_pix;
  logic        last_odd;
  logic        prev_v = 1'b0;

  always @(posedge pclock) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [L-1:0] d, input logic rec,
                      input logic fl);
    data      = d;
    record_in = rec;
    flush     = fl;
    @(posedge pclock);
    #1;
  endtask

  function automatic logic [L-1:0] lane_bits(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int p);
    logic [L-1:0] r;
    int bi;
    bi = PB - 1 - p / 2;
    for (int i = 0; i < L; i++)
      r[i] = (p % 2 == 0) ? a[8*i+bi] : b[8*i+bi];
    return r;
  endfunction

  task automatic push_exp(input logic [63:0] pe, input logic [63:0] pm,
                          input string nm);
    exp_t e;
    e.pix  = (MIR && mpar) ? pm : pe;
    e.odd  = mpar;
    e.cnt  = mcnt + 16'd1;
    e.cyc  = cyc_n;
    e.name = nm;
    sbq.push_back(e);
    last_pix = e.pix;
    last_odd = e.odd;
    mpar = ~mpar;
    mcnt = mcnt + 16'd1;
  endtask

  task automatic send_kernel(input vec_t v, input string nm);
    for (int p = 0; p < 2 * PB; p++) begin
      tick(lane_bits(v.a, v.b, p), 1'b1, 1'b0);
      if (p == 2 * PB - 1) push_exp(v.exp_even, v.exp_mir, nm);
      if (p == v.gap_at)
        repeat (v.gap_len) tick(L'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic send_partial(input vec_t v, input int n);
    for (int p = 0; p < n; p++)
      tick(lane_bits(v.a, v.b, p), 1'b1, 1'b0);
  endtask

  always @(negedge pclock) begin
    if (valid) begin
      chk("valid_back_to_back", 64'(prev_v), 64'd0);
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_valid: got valid=1 want none queued");
      end else begin
        me = sbq.pop_front();
        chk({me.name, "_pixels"}, pixels, me.pix);
        chk({me.name, "_odd"}, 64'(kernel_odd), 64'(me.odd));
        chk({me.name, "_count"}, 64'(kernel_count), 64'(me.cnt));
        chk({me.name, "_cycle"}, 64'(cyc_n), 64'(me.cyc));
      end
    end
    prev_v = valid;
  end

  initial begin
    #600000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  a1;
    logic [9:0]  b1;
    logic [19:0] e1;
    vt[0] = '{32'h3A2A1A0A, 32'h3B2B1B0B, -1, 0,
              64'h0A0B1A1B2A2B3A3B, 64'h3B3A2B2A1B1A0B0A};
    vt[1] = vt[0];
    vt[2] = '{32'h3A2A1A0A, 32'h3B2B1B0B, 5, 3,
              64'h0A0B1A1B2A2B3A3B, 64'h3B3A2B2A1B1A0B0A};
    vt[3] = '{32'h44332211, 32'h88776655, -1, 0,
              64'h1155226633774488, 64'h8844773366225511};
    vt[4] = '{32'hFF00FF00, 32'h0000FFFF, 0, 2,
              64'h00FFFFFF0000FF00, 64'h00FF0000FFFFFF00};
    vt[5] = '{32'h12345678, 32'h9ABCDEF0, 14, 1,
              64'h78F056DE34BC129A, 64'h9A12BC34DE56F078};
    vt[6] = '{32'h80808080, 32'h01010101, -1, 0,
              64'h8001800180018001, 64'h0180018001800180};

    reset = 1'b1; data1 = '0; rec1 = 1'b0; flush1 = 1'b0;
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b0, 1'b0);
    chk("rst_pixels", pixels, 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_odd", 64'(kernel_odd), 64'd0);
    chk("rst_count", 64'(kernel_count), 64'd0);
    chk("rst_u1_pixels", 64'(pixels1), 64'd0);
    reset = 1'b0;
    mpar = 1'b0;
    mcnt = '0;

    for (int k = 0; k < 7; k++) send_kernel(vt[k], $sformatf("vec%0d", k));
    repeat (3) tick('0, 1'b0, 1'b0);

    // flush mid-kernel with record_in high, then a clean kernel
    send_partial(vt[0], 9);
    tick(lane_bits(vt[0].a, vt[0].b, 9), 1'b1, 1'b1);
    mpar = 1'b0;
    mcnt = '0;
    chk("flush_hold_pixels", pixels, last_pix);
    chk("flush_hold_odd", 64'(kernel_odd), 64'(last_odd));
    chk("flush_count", 64'(kernel_count), 64'd0);
    send_kernel(vt[3], "after_flush");
    repeat (2) tick('0, 1'b0, 1'b0);

    // flush on the completing cycle discards the kernel
    send_partial(vt[4], 2 * PB - 1);
    tick(lane_bits(vt[4].a, vt[4].b, 2 * PB - 1), 1'b1, 1'b1);
    mpar = 1'b0;
    mcnt = '0;
    repeat (2) tick('0, 1'b0, 1'b0);
    chk("flush_last_valid", 64'(valid), 64'd0);
    chk("flush_last_count", 64'(kernel_count), 64'd0);
    send_kernel(vt[5], "after_flush_last");
    repeat (2) tick('0, 1'b0, 1'b0);

    // reset in the middle of a kernel overrides record_in
    send_partial(vt[3], 12);
    reset = 1'b1;
    tick(L'($urandom), 1'b1, 1'b0);
    reset = 1'b0;
    chk("midrst_pixels", pixels, 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_odd", 64'(kernel_odd), 64'd0);
    chk("midrst_count", 64'(kernel_count), 64'd0);
    mpar = 1'b0;
    mcnt = '0;
    send_kernel(vt[0], "after_reset");
    repeat (2) tick('0, 1'b0, 1'b0);

    // single-lane 10-bit instance: one valid per 20 recorded cycles
    for (int k = 0; k < 3; k++) begin
      a1 = 10'h2A5 ^ 10'(k);
      b1 = 10'h15A + 10'(k);
      for (int p = 0; p < 20; p++) begin
        data1 = (p % 2 == 0) ? a1[9-p/2] : b1[9-p/2];
        rec1  = 1'b1;
        @(posedge pclock);
        #1;
        if (p == 0 && k > 0)
          chk($sformatf("u1_k%0d_no_repeat", k), 64'(valid1), 64'd0);
        if (p == 18)
          chk($sformatf("u1_k%0d_no_early", k), 64'(valid1), 64'd0);
        if (p == 7 && k == 1) begin
          rec1 = 1'b0;
          repeat (2) @(posedge pclock);
          #1;
        end
      end
      rec1 = 1'b0;
      e1 = (MIR && (k % 2 == 1)) ? {b1, a1} : {a1, b1};
      chk($sformatf("u1_k%0d_valid", k), 64'(valid1), 64'd1);
      chk($sformatf("u1_k%0d_pixels", k), 64'(pixels1), 64'(e1));
      chk($sformatf("u1_k%0d_odd", k), 64'(odd1), 64'(k % 2));
      chk($sformatf("u1_k%0d_count", k), 64'(cnt1), 64'(k + 1));
    end

    repeat (3) tick('0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
